// File: rtl/divider_array_scheduler.sv
// divider_array_scheduler: round-robin sharing of one combinational 16/8 array
// divider between two requesters, with multicycle settle and valid/ready results.
`default_nettype none

module divider_array_scheduler #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_n,
    input  logic [7:0]  req0_d,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_n,
    input  logic [7:0]  req1_d,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [7:0]  rsp_q,
    output logic [7:0]  rsp_r,
    output logic [1:0]  rsp_err,
    output logic [15:0] div_n,
    output logic [7:0]  div_d,
    input  logic [7:0]  div_q,
    input  logic [7:0]  div_r,
    output logic        busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EVAL = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [3:0] C_LOAD = 4'(SETTLE_CYCLES - 1);

    logic [1:0]  r_state;
    logic [15:0] r_op_n;
    logic [7:0]  r_op_d;
    logic        r_id;
    logic        r_last_grant;
    logic [3:0]  r_cnt;
    logic        r_rsp_valid;
    logic        r_rsp_id;
    logic [7:0]  r_rsp_q;
    logic [7:0]  r_rsp_r;
    logic [1:0]  r_rsp_err;

    logic w_idle;
    logic w_grant;
    logic w_accept;
    logic w_err_dz;
    logic w_err_ovf;

    // On a tie the requester not granted last wins; otherwise whoever is valid.
    assign w_idle    = (r_state == S_IDLE);
    assign w_grant   = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
    assign w_accept  = w_idle && (req0_valid || req1_valid);
    assign w_err_dz  = (r_op_d == 8'd0);
    assign w_err_ovf = !w_err_dz && (r_op_n[15:8] >= r_op_d);

    assign req0_ready = w_accept && !w_grant;
    assign req1_ready = w_accept && w_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_op_n       <= 16'd0;
            r_op_d       <= 8'd0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= 4'd0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_q      <= 8'd0;
            r_rsp_r      <= 8'd0;
            r_rsp_err    <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op_n       <= w_grant ? req1_n : req0_n;
                        r_op_d       <= w_grant ? req1_d : req0_d;
                        r_id         <= w_grant;
                        r_last_grant <= w_grant;
                        r_cnt        <= C_LOAD;
                        r_state      <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (r_cnt == 4'd0) begin
                        // Error cases bypass the array outputs entirely.
                        if (w_err_dz || w_err_ovf) begin
                            r_rsp_q <= 8'hFF;
                            r_rsp_r <= r_op_n[7:0];
                        end else begin
                            r_rsp_q <= div_q;
                            r_rsp_r <= div_r;
                        end
                        r_rsp_err   <= {w_err_ovf, w_err_dz};
                        r_rsp_id    <= r_id;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_q     = r_rsp_q;
    assign rsp_r     = r_rsp_r;
    assign rsp_err   = r_rsp_err;
    assign div_n     = r_op_n;
    assign div_d     = r_op_d;
    assign busy      = !w_idle;

endmodule

`default_nettype wire

// File: tb/tb_divider_array_scheduler.sv
// tb_divider_array_scheduler: directed self-checking bench with an exact-divider stub.
`default_nettype none

module tb_divider_array_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [15:0] req0_n, req1_n, div_n;
    logic [7:0]  req0_d, req1_d, div_d, div_q, div_r, rsp_q, rsp_r;
    logic        rsp_valid, rsp_ready, rsp_id, busy;
    logic [1:0]  rsp_err;

    logic        rst_n_b, req0_valid_b, req0_ready_b, req1_ready_b, rsp_ready_b;
    logic        req1_valid_b;
    logic [15:0] req0_n_b, req1_n_b, div_n_b;
    logic [7:0]  req0_d_b, req1_d_b, div_d_b, div_q_b, div_r_b, rsp_q_b, rsp_r_b;
    logic        rsp_valid_b, rsp_id_b, busy_b;
    logic [1:0]  rsp_err_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign div_q   = (div_d == 8'd0)   ? 8'h00 : 8'(div_n / {8'h00, div_d});
    assign div_r   = (div_d == 8'd0)   ? 8'h00 : 8'(div_n % {8'h00, div_d});
    assign div_q_b = (div_d_b == 8'd0) ? 8'h00 : 8'(div_n_b / {8'h00, div_d_b});
    assign div_r_b = (div_d_b == 8'd0) ? 8'h00 : 8'(div_n_b % {8'h00, div_d_b});

    divider_array_scheduler #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_n(req0_n), .req0_d(req0_d),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_n(req1_n), .req1_d(req1_d),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_err(rsp_err),
        .div_n(div_n), .div_d(div_d), .div_q(div_q), .div_r(div_r), .busy(busy)
    );

    divider_array_scheduler #(.SETTLE_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n_b),
        .req0_valid(req0_valid_b), .req0_ready(req0_ready_b), .req0_n(req0_n_b), .req0_d(req0_d_b),
        .req1_valid(req1_valid_b), .req1_ready(req1_ready_b), .req1_n(req1_n_b), .req1_d(req1_d_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_id(rsp_id_b),
        .rsp_q(rsp_q_b), .rsp_r(rsp_r_b), .rsp_err(rsp_err_b),
        .div_n(div_n_b), .div_d(div_d_b), .div_q(div_q_b), .div_r(div_r_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Returns one cycle after the accepting edge with valid dropped.
    task automatic issue(input logic id, input logic [15:0] n, input logic [7:0] d);
        bit ok = 1'b0;
        if (id) begin req1_valid = 1'b1; req1_n = n; req1_d = d; end
        else    begin req0_valid = 1'b1; req0_n = n; req0_d = d; end
        for (int t = 0; t < 30 && !ok; t++) begin
            #1;
            ok = id ? req1_ready : req0_ready;
            tick();
        end
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
        if (!ok) check("issue_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        while (!rsp_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        if (!rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int cyc, na, nr, bad;
        int acc[8];
        logic rid[8];
        logic [7:0] rq[8];

        rst_n = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_n = '0; req0_d = '0; req1_n = '0; req1_d = '0;
        rst_n_b = 1'b0; rsp_ready_b = 1'b1; req0_valid_b = 1'b0; req1_valid_b = 1'b0;
        req0_n_b = '0; req0_d_b = '0; req1_n_b = '0; req1_d_b = '0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_div_n", 32'(div_n), 32'd0);
        check("rst_rsp_q", 32'(rsp_q), 32'd0);
        check("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
        rst_n = 1'b1;
        rst_n_b = 1'b1;
        tick();

        // Single op 100/7
        req0_valid = 1'b1; req0_n = 16'h0064; req0_d = 8'd7;
        #1;
        check("single_ready", 32'({req0_ready, req1_ready}), 32'b10);
        tick();
        req0_valid = 1'b0;
        check("single_busy", 32'(busy), 32'd1);
        check("single_div_n", 32'(div_n), 32'h0064);
        wait_rsp(cyc);
        check("single_latency", 32'(cyc), 32'd2);
        check("single_q", 32'(rsp_q), 32'd14);
        check("single_r", 32'(rsp_r), 32'd2);
        check("single_id_err", 32'({rsp_id, rsp_err}), 32'd0);
        rsp_ready = 1'b1;
        tick();
        check("single_drop", 32'({rsp_valid, busy}), 32'd0);

        // Tie arbitration from reset state
        do_reset();
        na = 0; nr = 0;
        req0_valid = 1'b1; req0_n = 16'd100; req0_d = 8'd10;
        req1_valid = 1'b1; req1_n = 16'd200; req1_d = 8'd9;
        for (int c = 0; c < 24; c++) begin
            #1;
            if ((req0_ready || req1_ready) && na < 8) begin acc[na] = c; na++; end
            if (rsp_valid && nr < 8) begin rid[nr] = rsp_id; rq[nr] = rsp_q; nr++; end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        check("tie_count", 32'(nr >= 4 && na >= 3), 32'd1);
        if (nr >= 4) begin
            check("tie_ids", 32'({rid[0], rid[1], rid[2], rid[3]}), 32'b0101);
            check("tie_q0", 32'(rq[0]), 32'd10);
            check("tie_q1", 32'(rq[1]), 32'd22);
        end
        if (na >= 3) begin
            check("tie_interval0", 32'(acc[1] - acc[0]), 32'd4);
            check("tie_interval1", 32'(acc[2] - acc[1]), 32'd4);
        end

        // Error cases
        issue(1'b1, 16'h1234, 8'd0);
        wait_rsp(cyc);
        check("dz_fields", {rsp_err, 5'd0, rsp_id, rsp_q, rsp_r, 8'd0}, {2'b01, 5'd0, 1'b1, 8'hFF, 8'h34, 8'd0});
        tick();
        issue(1'b0, 16'h0800, 8'h08);
        wait_rsp(cyc);
        check("ovf_fields", {rsp_err, 6'd0, rsp_q, rsp_r, 8'd0}, {2'b10, 6'd0, 8'hFF, 8'h00, 8'd0});
        tick();
        issue(1'b0, 16'h07FF, 8'h08);
        wait_rsp(cyc);
        check("bnd_fields", {rsp_err, 6'd0, rsp_q, rsp_r, 8'd0}, {2'b00, 6'd0, 8'hFF, 8'h07, 8'd0});
        tick();

        // Backpressure
        rsp_ready = 1'b0;
        issue(1'b0, 16'h0050, 8'd5);
        wait_rsp(cyc);
        req1_valid = 1'b1; req1_n = 16'h0031; req1_d = 8'd3;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (rsp_valid !== 1'b1 || rsp_q !== 8'd16 || rsp_r !== 8'd0 ||
                rsp_id !== 1'b0 || req1_ready !== 1'b0) bad++;
            tick();
        end
        check("bp_stable", 32'(bad), 32'd0);
        rsp_ready = 1'b1;
        tick();
        check("bp_release", 32'(rsp_valid), 32'd0);
        #1;
        check("bp_req1_ready", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        check("bp_accept", {15'd0, busy, div_n}, {15'd0, 1'b1, 16'h0031});
        wait_rsp(cyc);
        check("bp_result", {15'd0, rsp_id, rsp_q, rsp_r}, {15'd0, 1'b1, 8'd16, 8'd1});
        tick();

        // Reset mid-EVAL on the SETTLE_CYCLES=4 instance
        req0_valid_b = 1'b1; req0_n_b = 16'h00C8; req0_d_b = 8'h0A;
        #1;
        check("r4_ready", 32'(req0_ready_b), 32'd1);
        tick();
        req0_valid_b = 1'b0;
        check("r4_busy", 32'(busy_b), 32'd1);
        tick();
        tick();
        rst_n_b = 1'b0;
        #1;
        check("r4_async", {14'd0, busy_b, rsp_valid_b, div_n_b}, 32'd0);
        tick();
        rst_n_b = 1'b1;
        tick();
        req0_valid_b = 1'b1; req0_n_b = 16'h00C9; req0_d_b = 8'h0A;
        #1;
        check("r4_ready2", 32'(req0_ready_b), 32'd1);
        tick();
        req0_valid_b = 1'b0;
        cyc = 0;
        while (!rsp_valid_b && cyc < 40) begin
            tick();
            cyc++;
        end
        check("r4_latency", 32'(cyc), 32'd4);
        check("r4_result", {13'd0, rsp_err_b, rsp_id_b, rsp_q_b, rsp_r_b}, {13'd0, 2'b00, 1'b0, 8'd20, 8'd1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
